// File: rtl/axi4_lite_master_fsm_if.sv
// AXI4-Lite read/write channel bundle between a single-outstanding master and its slave.
// Signal names follow the AXI channel naming used across the bus fabric.
interface axi4_lite_master_fsm_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      AWVALID;
  logic                      AWREADY;
  logic [ADDR_WIDTH-1:0]     AWADDR;
  logic                      WVALID;
  logic                      WREADY;
  logic [DATA_WIDTH-1:0]     WDATA;
  logic [DATA_WIDTH/8-1:0]   WSTRB;
  logic                      BVALID;
  logic                      BREADY;
  logic [1:0]                BRESP;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [ADDR_WIDTH-1:0]     ARADDR;
  logic                      RVALID;
  logic                      RREADY;
  logic [DATA_WIDTH-1:0]     RDATA;
  logic [1:0]                RRESP;

  modport master (
    output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi4_lite_master_fsm.sv
// Single-outstanding AXI4-Lite master: turns one user command into an AR/R or AW/W/B
// exchange and returns exactly one response per command.
module axi4_lite_master_fsm #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [7:0]              err_count,
  axi4_lite_master_fsm_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [DATA_WIDTH/8-1:0] wstrb_r;
  logic                    aw_done_r;
  logic                    w_done_r;
  logic                    awvalid_r;
  logic                    wvalid_r;
  logic                    bready_r;
  logic                    arvalid_r;
  logic                    rready_r;
  logic                    cmd_ready_r;
  logic                    rsp_valid_r;
  logic                    rsp_write_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;
  logic [1:0]              rsp_resp_r;
  logic [7:0]              err_count_r;
  logic                    aw_done_s;
  logic                    w_done_s;

  function automatic logic [7:0] err_inc(input logic [7:0] cnt, input logic [1:0] resp);
    if ((resp != 2'b00) && (cnt != 8'hFF)) begin
      return cnt + 8'd1;
    end else begin
      return cnt;
    end
  endfunction

  // Channel completion including a handshake happening in the current cycle.
  always_comb begin
    aw_done_s = aw_done_r || (awvalid_r && bus.AWREADY);
    w_done_s  = w_done_r  || (wvalid_r  && bus.WREADY);
  end

  // Transaction FSM with all bus and response outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      addr_r      <= '0;
      wdata_r     <= '0;
      wstrb_r     <= '0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_resp_r  <= 2'b00;
      err_count_r <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            addr_r      <= cmd_addr;
            wdata_r     <= cmd_wdata;
            wstrb_r     <= cmd_wstrb;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            cmd_ready_r <= 1'b0;
            if (cmd_write) begin
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              state_r   <= WR_REQ;
            end else begin
              arvalid_r <= 1'b1;
              state_r   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          // AW and W retire independently; either may finish first.
          if (awvalid_r && bus.AWREADY) begin
            awvalid_r <= 1'b0;
            aw_done_r <= 1'b1;
          end
          if (wvalid_r && bus.WREADY) begin
            wvalid_r <= 1'b0;
            w_done_r <= 1'b1;
          end
          if (aw_done_s && w_done_s) begin
            bready_r <= 1'b1;
            state_r  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.BVALID) begin
            bready_r    <= 1'b0;
            rsp_resp_r  <= bus.BRESP;
            rsp_write_r <= 1'b1;
            rsp_rdata_r <= '0;
            rsp_valid_r <= 1'b1;
            err_count_r <= err_inc(err_count_r, bus.BRESP);
            state_r     <= RSP;
          end
        end
        RD_REQ: begin
          if (bus.ARREADY) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (bus.RVALID) begin
            rready_r    <= 1'b0;
            rsp_rdata_r <= bus.RDATA;
            rsp_resp_r  <= bus.RRESP;
            rsp_write_r <= 1'b0;
            rsp_valid_r <= 1'b1;
            err_count_r <= err_inc(err_count_r, bus.RRESP);
            state_r     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          bready_r    <= 1'b0;
          arvalid_r   <= 1'b0;
          rready_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_write   = rsp_write_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_resp    = rsp_resp_r;
  assign err_count   = err_count_r;
  assign bus.AWVALID = awvalid_r;
  assign bus.AWADDR  = addr_r;
  assign bus.WVALID  = wvalid_r;
  assign bus.WDATA   = wdata_r;
  assign bus.WSTRB   = wstrb_r;
  assign bus.BREADY  = bready_r;
  assign bus.ARVALID = arvalid_r;
  assign bus.ARADDR  = addr_r;
  assign bus.RREADY  = rready_r;

endmodule

// File: tb/tb_axi4_lite_master_fsm.sv
// Directed bench for axi4_lite_master_fsm: a latency-programmable slave, a transaction-level
// response/error model checked every cycle, and literal expectations for the main scenarios.
module tb_axi4_lite_master_fsm;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [7:0]    err_count;

  axi4_lite_master_fsm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_master_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .err_count(err_count),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave configuration (written by the test sequence between transactions)
  int         aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  int         gate = 0;  // 0: independent, 1: W waits for AW, 2: AW waits for W
  logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;

  // Slave state
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  bit aw_fire, aw_done, w_fire, w_done, b_fire, ar_fire, ar_done, r_fire;

  // Transaction-level model
  typedef struct { logic w; logic [31:0] d; logic [1:0] r; } rsp_t;
  rsp_t        q[$];
  rsp_t        e;
  bit          busy;
  logic [31:0] cur_addr, cur_data;
  logic [3:0]  cur_strb;
  int          model_err, n_cmd, n_rsp, exp_err;
  bit          m_aw_hs, m_w_hs, m_ar_hs;
  bit          seen_awlo_whi, seen_wlo_awhi;
  bit          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_rr;

  // Slave responder followed by the per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0; bus.BRESP = 2'b00;
      bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RDATA = 32'h0; bus.RRESP = 2'b00;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_fire = 0; aw_done = 0; w_fire = 0; w_done = 0; b_fire = 0;
      ar_fire = 0; ar_done = 0; r_fire = 0;
      q.delete(); busy = 0; model_err = 0; n_cmd = n_rsp;
      m_aw_hs = 0; m_w_hs = 0; m_ar_hs = 0;
      p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_rv = 0; p_rr = 0;
    end else begin
      if (b_fire) begin
        bus.BVALID = 1'b0;
        aw_fire = 0; aw_done = 0; w_fire = 0; w_done = 0; b_fire = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end
      if (aw_fire && !aw_done) begin aw_done = 1; bus.AWREADY = 1'b0; end
      if (w_fire && !w_done) begin w_done = 1; bus.WREADY = 1'b0; end
      if (!aw_fire && bus.AWVALID && (gate != 2 || w_done)) begin
        if (aw_cnt >= aw_lat) begin bus.AWREADY = 1'b1; aw_fire = 1; end
        else aw_cnt++;
      end
      if (!w_fire && bus.WVALID && (gate != 1 || aw_done)) begin
        if (w_cnt >= w_lat) begin bus.WREADY = 1'b1; w_fire = 1; end
        else w_cnt++;
      end
      if (aw_done && w_done && !b_fire) begin
        if (bus.BVALID || b_cnt >= b_lat) begin
          bus.BVALID = 1'b1; bus.BRESP = cfg_bresp;
          if (bus.BREADY) b_fire = 1;
        end else b_cnt++;
      end
      if (r_fire) begin
        bus.RVALID = 1'b0; ar_fire = 0; ar_done = 0; r_fire = 0; ar_cnt = 0; r_cnt = 0;
      end
      if (ar_fire && !ar_done) begin ar_done = 1; bus.ARREADY = 1'b0; end
      if (!ar_fire && bus.ARVALID) begin
        if (ar_cnt >= ar_lat) begin bus.ARREADY = 1'b1; ar_fire = 1; end
        else ar_cnt++;
      end
      if (ar_done && !r_fire) begin
        if (bus.RVALID || r_cnt >= r_lat) begin
          bus.RVALID = 1'b1; bus.RDATA = cfg_rdata; bus.RRESP = cfg_rresp;
          if (bus.RREADY) r_fire = 1;
        end else r_cnt++;
      end

      // Compare DUT outputs with the model
      chk("cmd_ready", cmd_ready, !busy);
      if (p_awv) chk("awvalid_hold", bus.AWVALID, !p_awr);
      if (p_wv)  chk("wvalid_hold", bus.WVALID, !p_wr);
      if (p_arv) chk("arvalid_hold", bus.ARVALID, !p_arr);
      if (bus.AWVALID) chk("awaddr", bus.AWADDR, cur_addr);
      if (bus.WVALID) begin
        chk("wdata", bus.WDATA, cur_data);
        chk("wstrb", bus.WSTRB, cur_strb);
      end
      if (bus.ARVALID) chk("araddr", bus.ARADDR, cur_addr);
      if (bus.BREADY) chk("bready_before_aw_w", m_aw_hs && m_w_hs, 1'b1);
      if (bus.RREADY) chk("rready_before_ar", m_ar_hs, 1'b1);
      if (p_rv && !p_rr) chk("rsp_valid_hold", rsp_valid, 1'b1);

      exp_err = model_err;
      if (rsp_valid && q.size() != 0 && q[0].r != 2'b00 && model_err < 255) exp_err = model_err + 1;
      chk("err_count", err_count, exp_err);

      if (rsp_valid) begin
        if (q.size() == 0) chk("rsp_spurious", rsp_valid, 1'b0);
        else begin
          chk("rsp_write", rsp_write, q[0].w);
          chk("rsp_rdata", rsp_rdata, q[0].d);
          chk("rsp_resp", rsp_resp, q[0].r);
          if (rsp_ready) begin
            void'(q.pop_front());
            model_err = exp_err;
            n_rsp++;
            busy = 0;
          end
        end
      end

      if (cmd_valid && cmd_ready) begin
        busy = 1; cur_addr = cmd_addr; cur_data = cmd_wdata; cur_strb = cmd_wstrb;
        e.w = cmd_write;
        e.d = cmd_write ? 32'h0 : cfg_rdata;
        e.r = cmd_write ? cfg_bresp : cfg_rresp;
        q.push_back(e);
        n_cmd++;
        m_aw_hs = 0; m_w_hs = 0; m_ar_hs = 0;
        seen_awlo_whi = 0; seen_wlo_awhi = 0;
      end
      if (bus.AWVALID && bus.AWREADY) m_aw_hs = 1;
      if (bus.WVALID && bus.WREADY)   m_w_hs = 1;
      if (bus.ARVALID && bus.ARREADY) m_ar_hs = 1;
      if (busy && !bus.AWVALID && bus.WVALID) seen_awlo_whi = 1;
      if (busy && bus.AWVALID && !bus.WVALID) seen_wlo_awhi = 1;

      p_awv = bus.AWVALID; p_awr = bus.AWREADY;
      p_wv  = bus.WVALID;  p_wr  = bus.WREADY;
      p_arv = bus.ARVALID; p_arr = bus.ARREADY;
      p_rv  = rsp_valid;   p_rr  = rsp_ready;
    end
  end

  task automatic set_slave(input int aw, input int w, input int b, input int ar, input int r,
                           input int g);
    aw_lat = aw; w_lat = w; b_lat = b; ar_lat = ar; r_lat = r; gate = g;
  endtask

  // Called at posedge+1; returns one cycle after acceptance with acc = acceptance cycle.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int acc);
    int n;
    n = 0;
    acc = -1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (cmd_ready) acc = cyc;
    else chk("cmd_accept_timeout", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int acc, output int lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin @(posedge clk); #1; n++; end
    if (rsp_valid) lat = cyc - acc;
    else begin
      lat = -1;
      chk("rsp_timeout", rsp_valid, 1'b1);
    end
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int acc, lat;
    issue(1'b1, a, d, 4'hF, acc);
    wait_rsp(acc, lat);
    ack_rsp();
  endtask

  int acc, lat, base;

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_awvalid", bus.AWVALID, 1'b0);
    chk("rst_wvalid", bus.WVALID, 1'b0);
    chk("rst_arvalid", bus.ARVALID, 1'b0);
    chk("rst_bready", bus.BREADY, 1'b0);
    chk("rst_rready", bus.RREADY, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_err_count", err_count, 8'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Ideal write
    set_slave(0, 0, 0, 0, 0, 0);
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, acc);
    chk("ideal_awvalid", bus.AWVALID, 1'b1);
    chk("ideal_awaddr", bus.AWADDR, 32'h10);
    chk("ideal_wdata", bus.WDATA, 32'hDEADBEEF);
    wait_rsp(acc, lat);
    chk("ideal_wr_latency", lat, 3);
    chk("ideal_rsp_write", rsp_write, 1'b1);
    chk("ideal_rsp_resp", rsp_resp, 2'b00);
    ack_rsp();

    // Sequential slave: AW after 2, W 3 after AW, B 2 later
    base = n_rsp;
    set_slave(2, 3, 2, 0, 0, 1);
    issue(1'b1, 32'h20, 32'hA5A50001, 4'h3, acc);
    wait_rsp(acc, lat);
    chk("seq_latency", lat, 11);
    ack_rsp();
    repeat (4) @(posedge clk);
    #1;
    chk("seq_aw_low_w_high", seen_awlo_whi, 1'b1);
    chk("seq_one_response", n_rsp - base, 1);

    // W before AW
    set_slave(4, 0, 0, 0, 0, 2);
    issue(1'b1, 32'h30, 32'h0BADF00D, 4'hC, acc);
    wait_rsp(acc, lat);
    chk("w_first_latency", lat, 8);
    chk("w_first_w_low_aw_high", seen_wlo_awhi, 1'b1);
    ack_rsp();

    // Read with AR delay and response backpressure
    set_slave(0, 0, 0, 3, 0, 0);
    cfg_rdata = 32'h12345678; cfg_rresp = 2'b00;
    issue(1'b0, 32'h24, 32'h0, 4'h0, acc);
    chk("rd_araddr", bus.ARADDR, 32'h24);
    wait_rsp(acc, lat);
    chk("rd_bp_latency", lat, 6);
    for (int i = 0; i < 5; i++) begin
      chk("rd_rdata_stable", rsp_rdata, 32'h12345678);
      chk("rd_cmd_ready_low", cmd_ready, 1'b0);
      @(posedge clk); #1;
    end
    chk("rd_rsp_write", rsp_write, 1'b0);
    ack_rsp();
    chk("rd_cmd_ready_after", cmd_ready, 1'b1);

    // Error counting and saturation
    set_slave(0, 0, 0, 0, 0, 0);
    cfg_bresp = 2'b10;
    for (int i = 0; i < 3; i++) do_write(32'h40 + 32'(i * 4), 32'hE0 + 32'(i));
    chk("err_count_3", err_count, 8'd3);
    for (int i = 0; i < 300; i++) do_write(32'h100, 32'(i));
    chk("err_count_sat", err_count, 8'd255);
    cfg_bresp = 2'b00;

    // Asynchronous reset in the middle of WR_REQ
    set_slave(1000, 1000, 0, 0, 0, 0);
    issue(1'b1, 32'h50, 32'h55AA55AA, 4'hF, acc);
    chk("mid_awvalid_before_rst", bus.AWVALID, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_awvalid", bus.AWVALID, 1'b0);
    chk("mid_rst_wvalid", bus.WVALID, 1'b0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
    chk("mid_rst_err_count", err_count, 8'd0);
    set_slave(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Recovery after reset
    issue(1'b1, 32'h60, 32'hCAFEF00D, 4'hF, acc);
    wait_rsp(acc, lat);
    chk("post_rst_latency", lat, 3);
    ack_rsp();
    repeat (3) @(posedge clk);
    #1;
    chk("rsp_count", n_rsp, n_cmd);
    chk("rsp_queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
